// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Optional macro MUL_RADIX4_EN: the multiplier retires 2 multiplier bits per cycle.
//
// state  | meaning
// S_IDLE | ready for a request
// S_MUL  | multiply iterations in flight
// S_DONE | result held until the consumer takes it
module alu_exec_unit #(
   parameter int WIDTH = 32,
`ifdef MUL_RADIX4_EN
   parameter int MUL_CYCLES = WIDTH / 2
`else
   parameter int MUL_CYCLES = WIDTH
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       ALUctl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             busy_o
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
`ifdef MUL_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_XOR = 3'd1;
   localparam logic [2:0] OP_SLL = 3'd2;
   localparam logic [2:0] OP_ADD = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_SRA = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic             mul_load;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] acc_sum;

   assign in_ready_o  = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign result_o    = result_q;
   assign zero_o      = zero_q;

   // A flush in IDLE blocks acceptance even though in_ready_o stays high.
   assign accept   = in_valid_i && in_ready_o && !flush_i;
   assign mul_load = accept && (ALUctl_i == OP_MUL);
   assign shamt    = data2_i[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (ALUctl_i)
         OP_AND:  alu_res = data1_i & data2_i;
         OP_XOR:  alu_res = data1_i ^ data2_i;
         OP_SLL:  alu_res = data1_i << shamt;
         OP_ADD:  alu_res = data1_i + data2_i;
         OP_SUB:  alu_res = data1_i - data2_i;
         OP_SRA:  alu_res = $unsigned($signed(data1_i) >>> shamt);
         default: alu_res = '0;
      endcase
   end

`ifdef MUL_RADIX4_EN
   logic [WIDTH-1:0] mcand3_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mcand3_q <= '0;
      end else if (mul_load) begin
         mcand3_q <= data1_i + (data1_i << 1);
      end else if (state_q == S_MUL) begin
         mcand3_q <= mcand3_q << 2;
      end
   end

   always_comb begin
      partial = '0;
      case (mplier_q[1:0])
         2'd0:    partial = '0;
         2'd1:    partial = mcand_q;
         2'd2:    partial = mcand_q << 1;
         default: partial = mcand3_q;
      endcase
   end
`else
   always_comb begin
      partial = '0;
      if (mplier_q[0]) begin
         partial = mcand_q;
      end
   end
`endif

   assign acc_sum = acc_q + partial;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (mul_load) begin
               mcand_d  = data1_i;
               mplier_d = data2_i;
               acc_d    = '0;
               cnt_d    = CW'(MUL_CYCLES - 1);
               state_d  = S_MUL;
            end else if (accept) begin
               result_d = alu_res;
               zero_d   = (alu_res == '0);
               state_d  = S_DONE;
            end
         end
         S_MUL: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d    = acc_sum;
               mcand_d  = mcand_q << STEP;
               mplier_d = mplier_q >> STEP;
               // Down-counter: the terminal iteration folds its add straight into the result.
               if (cnt_q == '0) begin
                  result_d = acc_sum;
                  zero_d   = (acc_sum == '0);
                  state_d  = S_DONE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         S_DONE: begin
            if (flush_i || out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against a plain-arithmetic reference model.
module tb_alu_exec_unit;

   localparam int W = 32;
`ifdef MUL_RADIX4_EN
   localparam int MC = 16;
`else
   localparam int MC = 32;
`endif

   logic          clk_sys = 1'b0;
   logic          rst_b;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    alu_ctl;
   logic [W-1:0]  data1;
   logic [W-1:0]  data2;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          busy;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk_sys = ~clk_sys;

   alu_exec_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
      .clk_i       (clk_sys),
      .rst_i       (rst_b),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .ALUctl_i    (alu_ctl),
      .data1_i     (data1),
      .data2_i     (data2),
      .flush_i     (flush),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .zero_o      (zero),
      .busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] ctl, input logic [31:0] a,
                                           input logic [31:0] b);
      longint unsigned prod;
      int sh;
      sh = int'(b[4:0]);
      case (ctl)
         3'd0: return a & b;
         3'd1: return a ^ b;
         3'd2: return a << sh;
         3'd3: return a + b;
         3'd4: return a - b;
         3'd5: begin
            prod = longint'(a) * longint'(b);
            return prod[31:0];
         end
         3'd6: return $unsigned($signed(a) >>> sh);
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Issue one op, hold the result for `hold` cycles of backpressure, then drain it.
   task automatic run_op(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [31:0] exp;
      logic [31:0] held;
      int lat;
      bit rdy_seen;
      exp = ref_alu(ctl, a, b);
      data1 = a; data2 = b; alu_ctl = ctl;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      data1 = $urandom; data2 = $urandom; alu_ctl = 3'($urandom_range(0, 7));
      lat = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_seen = 1'b1;
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), (ctl == 3'd5) ? 32'(MC + 1) : 32'd1);
      chk({tag, " in_ready while busy"}, 32'(rdy_seen), 32'd0);
      chk({tag, " result"}, result, exp);
      chk({tag, " zero"}, 32'(zero), 32'(exp == 32'h0));
      held = result;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, " held result"}, result, held);
         chk({tag, " held valid/ready"}, {30'h0, out_valid, in_ready}, 32'h2);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " drained valid/ready"}, {30'h0, out_valid, in_ready}, 32'h1);
   endtask

   task automatic start_op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
      data1 = a; data2 = b; alu_ctl = ctl; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      logic [2:0]  ctl;
      rst_b = 1'b0; in_valid = 1'b0; alu_ctl = '0; data1 = '0; data2 = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      chk("reset flags", {27'h0, in_ready, out_valid, busy, zero, 1'b0}, 32'h10);
      chk("reset result", result, 32'h0);
      rst_b = 1'b1;
      tick();

      run_op("add 5+7", 3'd3, 32'd5, 32'd7, 0);
      run_op("sub 3-3", 3'd4, 32'd3, 32'd3, 0);
      run_op("xor", 3'd1, 32'h0000F0F0, 32'h0000FFFF, 0);
      run_op("and", 3'd0, 32'hFF00FF00, 32'h0FF00FF0, 0);
      run_op("sll 31", 3'd2, 32'h1, 32'd31, 0);
      run_op("sra 4", 3'd6, 32'h80000000, 32'd4, 0);
      run_op("sra 30", 3'd6, 32'h40000000, 32'd30, 0);
      run_op("sll amt 0x21", 3'd2, 32'h3, 32'h21, 0);
      run_op("sra amt 0x21", 3'd6, 32'h80000000, 32'h21, 0);
      run_op("mul ffff^2", 3'd5, 32'h0000FFFF, 32'h0000FFFF, 0);
      run_op("mul -3x7", 3'd5, 32'hFFFFFFFD, 32'd7, 0);
      run_op("mul by 0", 3'd5, 32'h12345678, 32'h0, 0);
      run_op("backpressure add", 3'd3, 32'd1, 32'd1, 5);
      run_op("reserved", 3'd7, 32'hDEADBEEF, 32'h1234, 0);

      // Reset while a result is waiting in DONE.
      out_ready = 1'b0;
      start_op(3'd3, 32'd9, 32'd9);
      rst_b = 1'b0;
      #1;
      chk("async reset flags", {28'h0, in_ready, out_valid, busy, zero}, 32'h8);
      chk("async reset result", result, 32'h0);
      tick();
      rst_b = 1'b1;
      tick();

      // Reset ten cycles into a multiply.
      start_op(3'd5, 32'h0000FFFF, 32'h0000FFFF);
      repeat (10) tick();
      rst_b = 1'b0;
      #1;
      chk("reset in mul busy", 32'(busy), 32'd0);
      tick();
      rst_b = 1'b1;
      watch_no_valid("reset in mul no valid", MC + 10);

      // Flush eight cycles into a multiply.
      start_op(3'd5, 32'h00001234, 32'h00005678);
      repeat (7) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush mul state", {29'h0, in_ready, out_valid, busy}, 32'h4);
      watch_no_valid("flush mul no valid", MC + 10);

      // Flush in IDLE blocks acceptance.
      flush = 1'b1; in_valid = 1'b1; alu_ctl = 3'd3; data1 = 32'd1; data2 = 32'd2;
      chk("flush idle ready", 32'(in_ready), 32'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush idle no accept", {30'h0, out_valid, busy}, 32'h0);

      // Flush in DONE discards the held result.
      start_op(3'd4, 32'd10, 32'd4);
      chk("pre-flush done valid", 32'(out_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush done state", {30'h0, out_valid, in_ready}, 32'h1);
      tick();

      for (int n = 0; n < 50; n++) begin
         ctl = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       a = 32'h0;
            1:       a = 32'hFFFFFFFF;
            2:       a = 32'h80000000;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         run_op($sformatf("rand%0d op%0d", n, ctl), ctl, a, b, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
